approx_mac_accum: RTL and testbench

//  Accumulator stage directly downstream of the dual-stage approximate 4:2 compressor tree.
//  - Takes the tree's carry-save (sum, carry) vectors and resolves them to one signed addend.
//  - Accumulates addends over one dot-product vector, with saturation.
//  - Presents the result over a valid/ready handshake.
//  - Drives the compressor tree's enable so the tree is gated while this stage stalls.

---
 rtl/approx_mac_pkg.sv | 38 +++
 rtl/approx_mac_accum_if.sv | 34 +++
 rtl/approx_cs_resolve.sv | 26 ++
 rtl/approx_mac_accum.sv | 134 +++++++++++++
 tb/tb_approx_mac_accum.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/approx_mac_pkg.sv
`default_nettype none
// ============================================================================
// approx_mac_pkg : shared widths, FSM state encoding and saturating add
// Rev 1.0
// ============================================================================
package approx_mac_pkg;

    localparam int PP_W  = 16;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } state_t;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [CNT_W-1:0]        cnt_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {clamped, result}; overflow shows as the two top bits of the
    // one-bit-wider sum disagreeing, and the wider MSB gives the true sign.
    function automatic logic [ACC_W:0] sat_add(input acc_t a, input acc_t b);
        logic [ACC_W:0] wide;
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            return wide[ACC_W] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
        end
        return {1'b0, wide[ACC_W-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_mac_accum_if.sv
`default_nettype none
// ============================================================================
// approx_mac_accum_if : beat-in / result-out handshake bundle of the accumulator
// Rev 1.0
// ============================================================================
interface approx_mac_accum_if;
    import approx_mac_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PP_W-1:0]  in_sum;
    logic [PP_W-1:0]  in_carry;
    logic             in_last;
    logic             comp_enable;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    // Accumulator side
    modport slave (
        input  in_valid, in_sum, in_carry, in_last, out_ready,
        output in_ready, comp_enable, out_valid, out_acc, out_count, out_sat
    );

    // Compressor tree / consumer side
    modport master (
        output in_valid, in_sum, in_carry, in_last, out_ready,
        input  in_ready, comp_enable, out_valid, out_acc, out_count, out_sat
    );

endinterface
`default_nettype wire

// File: rtl/approx_cs_resolve.sv
`default_nettype none
// ============================================================================
// approx_cs_resolve : sign-extend carry-save pair and add carry at weight x2
// Rev 1.0
// ============================================================================
module approx_cs_resolve #(
    parameter int PP_W  = 16,
    parameter int ACC_W = 24
) (
    input  wire logic [PP_W-1:0]         sum,
    input  wire logic [PP_W-1:0]         carry,
    output logic signed [ACC_W-1:0]      addend
);

    logic [ACC_W-1:0] w_sum_ext;
    logic [ACC_W-1:0] w_carry_ext;
    logic [ACC_W-1:0] w_carry_x2;

    // Extend before shifting so the carry's sign survives the x2 weight.
    assign w_sum_ext   = {{(ACC_W-PP_W){sum[PP_W-1]}}, sum};
    assign w_carry_ext = {{(ACC_W-PP_W){carry[PP_W-1]}}, carry};
    assign w_carry_x2  = {w_carry_ext[ACC_W-2:0], 1'b0};
    assign addend      = w_sum_ext + w_carry_x2;

endmodule
`default_nettype wire

// File: rtl/approx_mac_accum.sv
`default_nettype none
// ============================================================================
// approx_mac_accum : two-stage saturating accumulator behind the compressor tree
// Rev 1.0
// ============================================================================
module approx_mac_accum
    import approx_mac_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clear,
    approx_mac_accum_if.slave bus
);

    acc_t           w_addend;
    logic           w_stall;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_advance;
    logic [ACC_W:0] w_sum_sat;
    logic           w_sat_hit;
    acc_t           w_acc_next;
    cnt_t           w_cnt_next;

    acc_t   r_a_add;
    logic   r_a_last;
    logic   r_a_vld;
    acc_t   r_acc;
    cnt_t   r_cnt;
    logic   r_sat;
    logic   r_out_valid;
    acc_t   r_out_acc;
    cnt_t   r_out_count;
    logic   r_out_sat;
    state_t r_state;

    approx_cs_resolve #(
        .PP_W  (PP_W),
        .ACC_W (ACC_W)
    ) u_resolve (
        .sum    (bus.in_sum),
        .carry  (bus.in_carry),
        .addend (w_addend)
    );

    // Only a last beat can be blocked, and only by an unconsumed result.
    assign w_stall    = r_a_vld && r_a_last && r_out_valid && !bus.out_ready;
    assign w_in_ready = rst_n && !w_stall && !clear;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_advance  = r_a_vld && !w_stall;

    assign w_sum_sat  = sat_add(r_acc, r_a_add);
    assign w_sat_hit  = w_sum_sat[ACC_W];
    assign w_acc_next = w_sum_sat[ACC_W-1:0];
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_add     <= '0;
            r_a_last    <= 1'b0;
            r_a_vld     <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
            r_state     <= IDLE;
        end else if (clear) begin
            r_a_vld     <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
        end else begin
            // Stage A
            if (w_accept) begin
                r_a_add  <= w_addend;
                r_a_last <= bus.in_last;
                r_a_vld  <= 1'b1;
            end else if (w_advance) begin
                r_a_vld  <= 1'b0;
            end

            // Stage B: a last beat publishes and restarts the vector in one edge
            if (w_advance) begin
                if (r_a_last) begin
                    r_out_acc   <= w_acc_next;
                    r_out_count <= w_cnt_next;
                    r_out_sat   <= r_sat || w_sat_hit;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_sat       <= 1'b0;
                end else begin
                    r_acc       <= w_acc_next;
                    r_cnt       <= w_cnt_next;
                    r_sat       <= r_sat || w_sat_hit;
                end
            end

            if (w_advance && r_a_last) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_stall)                    r_state <= STALL;
                    else if (r_a_vld && !r_a_last)  r_state <= ACCUM;
                end
                ACCUM: begin
                    if (w_stall)                    r_state <= STALL;
                    else if (r_a_vld && r_a_last)   r_state <= IDLE;
                end
                STALL: begin
                    if (!w_stall)                   r_state <= IDLE;
                end
                default:                            r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.comp_enable = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_acc     = r_out_acc;
    assign bus.out_count   = r_out_count;
    assign bus.out_sat     = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_approx_mac_accum.sv
`default_nettype none
// ============================================================================
// tb_approx_mac_accum : directed self-checking bench for approx_mac_accum
// Rev 1.0
// ============================================================================
module tb_approx_mac_accum;

    logic clk;
    logic rst_n;
    logic clear;
    int   checks;
    int   errors;

    approx_mac_accum_if bus();

    approx_mac_accum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] s, input logic [15:0] c, input logic l);
        int waited;
        waited         = 0;
        bus.in_valid   = 1'b1;
        bus.in_sum     = s;
        bus.in_carry   = c;
        bus.in_last    = l;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 16'd9;
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_acc !== 24'h000000) begin errors++; $display("FAIL reset_out_acc got %h want 000000", bus.out_acc); end
        checks++; if (bus.out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", bus.out_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.comp_enable !== 1'b0) begin errors++; $display("FAIL reset_comp_enable got %0b want 0", bus.comp_enable); end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.comp_enable !== 1'b1) begin errors++; $display("FAIL release_comp_enable got %0b want 1", bus.comp_enable); end
        tick();
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send_beat(16'd5, 16'd3, 1'b0);
        send_beat(16'd2, 16'd1, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early got %0b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_acc !== 24'd15) begin errors++; $display("FAIL basic_out_acc got %0d want 15", bus.out_acc); end
        checks++; if (bus.out_count !== 8'd2) begin errors++; $display("FAIL basic_out_count got %0d want 2", bus.out_count); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL basic_out_sat got %0b want 0", bus.out_sat); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_negative();
        send_beat(16'hFFFE, 16'hFFFF, 1'b1);
        tick();
        checks++; if (bus.out_acc !== 24'hFFFFFC) begin errors++; $display("FAIL neg_out_acc got %h want FFFFFC", bus.out_acc); end
        checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL neg_out_count got %0d want 1", bus.out_count); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL neg_out_sat got %0b want 0", bus.out_sat); end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 129; i++) begin
            send_beat(16'h7FFF, 16'h3FFF, (i == 128));
        end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_acc !== 24'h7FFFFF) begin errors++; $display("FAIL sat_out_acc got %h want 7FFFFF", bus.out_acc); end
        checks++; if (bus.out_sat !== 1'b1) begin errors++; $display("FAIL sat_out_sat got %0b want 1", bus.out_sat); end
        checks++; if (bus.out_count !== 8'd129) begin errors++; $display("FAIL sat_out_count got %0d want 129", bus.out_count); end
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 16'd1;
        bus.in_carry  = 16'd0;
        bus.in_last   = 1'b1;
        tick();
        bus.in_sum    = 16'd2;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd1) begin errors++; $display("FAIL bp_first_held valid=%0b acc=%0d want 1/1", bus.out_valid, bus.out_acc); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.comp_enable !== 1'b0) begin errors++; $display("FAIL bp_comp_enable got %0b want 0", bus.comp_enable); end
        repeat (3) tick();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_acc !== 24'd1) begin errors++; $display("FAIL bp_stall_hold in_ready=%0b acc=%0d want 0/1", bus.in_ready, bus.out_acc); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %0b want 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd2) begin errors++; $display("FAIL bp_second valid=%0b acc=%0d want 1/2", bus.out_valid, bus.out_acc); end
        checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL bp_second_count got %0d want 1", bus.out_count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_clear_mid_vector();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(16'd7, 16'd0, 1'b0);
        clear         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 16'd9;
        bus.in_last   = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.comp_enable !== 1'b0) begin errors++; $display("FAIL clear_in_ready in_ready=%0b en=%0b want 0/0", bus.in_ready, bus.comp_enable); end
        tick();
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_result got %0b want 0", bus.out_valid); end
        send_beat(16'd1, 16'd0, 1'b1);
        tick();
        checks++; if (bus.out_acc !== 24'd1 || bus.out_count !== 8'd1) begin errors++; $display("FAIL clear_result acc=%0d cnt=%0d want 1/1", bus.out_acc, bus.out_count); end
        tick();
    endtask

    task automatic test_reset_mid_vector();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(16'd7, 16'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid in_ready=%0b valid=%0b want 0/0", bus.in_ready, bus.out_valid); end
        repeat (2) tick();
        rst_n = 1'b1;
        send_beat(16'd1, 16'd0, 1'b1);
        tick();
        checks++; if (bus.out_acc !== 24'd1 || bus.out_count !== 8'd1) begin errors++; $display("FAIL rst_result acc=%0d cnt=%0d want 1/1", bus.out_acc, bus.out_count); end
        tick();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_backpressure();
        test_clear_mid_vector();
        test_reset_mid_vector();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
